alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 50 +++++
 rtl/alu_arbiter_rr_arb2.sv | 28 ++
 rtl/alu_arbiter.sv | 142 ++++++++++++++
 tb/tb_alu_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// alu_arbiter_pkg
//   Shared definitions for the two-requester ALU arbiter:
//     state_t      - FSM state encoding (IDLE / EXEC / RESP)
//     OP_*         - opcodes that need non-default ALU control bits
//     alu_ctrl_t   - invert-A / invert-B / carry-in control bundle
//     decode_ctrl  - maps an opcode to its ALU control bundle
// ----------------------------------------------------------------------------
package alu_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b1001;
    localparam logic [3:0] OP_SLE  = 4'b1010;
    localparam logic [3:0] OP_ANDN = 4'b1101;

    typedef struct packed {
        logic inva;
        logic invb;
        logic cin;
    } alu_ctrl_t;

    // SUB computes ~a + b + 1; the compares compute a + ~b + 1;
    // ANDN only needs b inverted. Everything else runs with plain operands.
    function automatic alu_ctrl_t decode_ctrl(input logic [3:0] op);
        alu_ctrl_t ctrl;
        ctrl = '0;
        case (op)
            OP_SUB: begin
                ctrl.inva = 1'b1;
                ctrl.cin  = 1'b1;
            end
            OP_SLT, OP_SLE: begin
                ctrl.invb = 1'b1;
                ctrl.cin  = 1'b1;
            end
            OP_ANDN: begin
                ctrl.invb = 1'b1;
            end
            default: ctrl = '0;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
//   Two-way round-robin grant logic (purely combinational).
//   Ports:
//     req   [1:0] in   request vector, bit n = requester n
//     ptr         in   priority pointer: requester that wins a tie
//     grant [1:0] out  one-hot grant (zero when no request)
//   A lone requester always wins; the pointer only breaks ties.
// ----------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] grant
);

    always_comb begin
        // NOTE: default assignment first so no path leaves grant unassigned
        // (otherwise a latch is inferred).
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// ----------------------------------------------------------------------------
// alu_arbiter
//   Shares one external combinational ALU between two requesters. One
//   operation is in flight at a time: IDLE grants a requester and latches its
//   operation, EXEC drives the ALU and captures its result, RESP holds the
//   result until the consumer takes it.
//   Ports:
//     clk, rst                       clock, asynchronous active-high reset
//     req{0,1}_valid/_ready          request handshake per requester
//     req{0,1}_op/_a/_b              opcode and operands per requester
//     resp_valid/_ready              response handshake
//     resp_id/_data/_zero/_ofl       owning requester, result and flags
//     alu_op/_a/_b/_cin/_inva/_invb  drive to the shared ALU (zero outside EXEC)
//     alu_res/_zero/_ofl             shared ALU outputs
// ----------------------------------------------------------------------------
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,

    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_zero,
    output logic             resp_ofl,

    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cin,
    output logic             alu_inva,
    output logic             alu_invb,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_zero,
    input  logic             alu_ofl
);

    state_t     state;
    logic       ptr;
    logic       id_q;
    alu_ctrl_t  ctrl_q;
    logic [1:0] grant;
    logic       idle;

    logic [3:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    rr_arb2 u_arb (
        .req   ({req1_valid, req0_valid}),
        .ptr   (ptr),
        .grant (grant)
    );

    // Ready is combinational so a grant takes effect at the same edge that
    // latches the operation; it is held low throughout reset.
    assign idle       = (state == ST_IDLE) && !rst;
    assign req0_ready = idle && grant[0];
    assign req1_ready = idle && grant[1];

    assign sel_op = grant[1] ? req1_op : req0_op;
    assign sel_a  = grant[1] ? req1_a  : req0_a;
    assign sel_b  = grant[1] ? req1_b  : req0_b;

    assign alu_inva = ctrl_q.inva;
    assign alu_invb = ctrl_q.invb;
    assign alu_cin  = ctrl_q.cin;

    // The ALU drive registers double as the latched operation: loaded on
    // grant and cleared when EXEC ends, so the ALU sees zeros outside EXEC.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: every register, including the latched operands, is reset so
        // an aborted operation leaves nothing behind.
        if (rst) begin
            state      <= ST_IDLE;
            ptr        <= 1'b0;
            id_q       <= 1'b0;
            ctrl_q     <= '0;
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_data  <= '0;
            resp_zero  <= 1'b0;
            resp_ofl   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|grant) begin
                        id_q   <= grant[1];
                        alu_op <= sel_op;
                        alu_a  <= sel_a;
                        alu_b  <= sel_b;
                        ctrl_q <= decode_ctrl(sel_op);
                        // Priority moves to whichever requester did not win.
                        ptr    <= ~grant[1];
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    resp_valid <= 1'b1;
                    resp_id    <= id_q;
                    resp_data  <= alu_res;
                    resp_zero  <= alu_zero;
                    resp_ofl   <= alu_ofl;
                    alu_op     <= '0;
                    alu_a      <= '0;
                    alu_b      <= '0;
                    ctrl_q     <= '0;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// ----------------------------------------------------------------------------
// tb_alu_arbiter
//   Self-checking bench for alu_arbiter. A behavioural ALU answers the DUT's
//   alu_* drive. A negedge monitor runs a cycle-level reference of the
//   arbiter: it predicts grants, pushes the expected response into a
//   scoreboard queue at grant time and pops/compares it when the response
//   is taken. Directed checks at key cycles use hand-derived constants.
// ----------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int W = 16;

    typedef struct packed {
        logic         id;
        logic [W-1:0] data;
        logic         zero;
        logic         ofl;
    } resp_t;

    typedef enum logic [1:0] {M_IDLE, M_EXEC, M_RESP} mphase_t;

    logic         clk;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [3:0]   req0_op, req1_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         resp_valid, resp_ready, resp_id, resp_zero, resp_ofl;
    logic [W-1:0] resp_data;
    logic [3:0]   alu_op;
    logic [W-1:0] alu_a, alu_b, alu_res;
    logic         alu_cin, alu_inva, alu_invb, alu_zero, alu_ofl;

    logic         force_flags;
    int           n_checks;
    int           n_errors;

    resp_t        sb[$];
    logic         grant_log[$];
    logic         resp_log[$];

    mphase_t      m_phase;
    logic         m_ptr;
    logic [3:0]   m_op;
    logic [W-1:0] m_a, m_b;
    logic [1:0]   exp_grant;
    logic         g_id;

    logic [3:0]   dec_ops [4];
    logic [2:0]   dec_exp [4];

    alu_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_zero  (resp_zero),
        .resp_ofl   (resp_ofl),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_cin    (alu_cin),
        .alu_inva   (alu_inva),
        .alu_invb   (alu_invb),
        .alu_res    (alu_res),
        .alu_zero   (alu_zero),
        .alu_ofl    (alu_ofl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control bits {inva, invb, cin} for each opcode.
    function automatic logic [2:0] ctrl_ref(input logic [3:0] op);
        case (op)
            4'b0001:          return 3'b101;
            4'b1001, 4'b1010: return 3'b011;
            4'b1101:          return 3'b010;
            default:          return 3'b000;
        endcase
    endfunction

    // Behavioural ALU: returns {res, zero, ofl}.
    function automatic logic [W+1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic [2:0] c);
        logic [W-1:0] x, y, r;
        logic         o;
        if (force_flags) return {{W{1'b0}}, 1'b1, 1'b1};
        x = c[2] ? ~a : a;
        y = c[1] ? ~b : b;
        if (op == 4'b1101) begin
            r = x & y;
            o = 1'b0;
        end else begin
            r = x + y + {{(W-1){1'b0}}, c[0]};
            o = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
        end
        return {r, (r == '0), o};
    endfunction

    assign {alu_res, alu_zero, alu_ofl} = alu_fn(alu_op, alu_a, alu_b, {alu_inva, alu_invb, alu_cin});

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Cycle-level reference and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_outputs", 64'({req1_ready, req0_ready, resp_valid, resp_id, resp_data,
                                      resp_zero, resp_ofl, alu_op, alu_a, alu_b,
                                      alu_inva, alu_invb, alu_cin}), 64'(0));
            m_phase = M_IDLE;
            m_ptr   = 1'b0;
            sb.delete();
        end else begin
            exp_grant = 2'b00;
            if (m_phase == M_IDLE) begin
                if (req0_valid && req1_valid) exp_grant = m_ptr ? 2'b10 : 2'b01;
                else                          exp_grant = {req1_valid, req0_valid};
            end
            check("ready", 64'({req1_ready, req0_ready}), 64'(exp_grant));
            if (req0_ready || req1_ready) grant_log.push_back(req1_ready);

            if (m_phase == M_EXEC)
                check("alu_drive", 64'({alu_op, alu_a, alu_b, alu_inva, alu_invb, alu_cin}),
                      64'({m_op, m_a, m_b, ctrl_ref(m_op)}));
            else
                check("alu_quiet", 64'({alu_op, alu_a, alu_b, alu_inva, alu_invb, alu_cin}), 64'(0));

            if (m_phase == M_RESP) begin
                if (sb.size() == 0)
                    check("sb_underflow", 64'(sb.size()), 64'(1));
                else
                    check("resp", 64'({resp_valid, resp_id, resp_data, resp_zero, resp_ofl}),
                          64'({1'b1, sb[0]}));
                if (resp_valid && resp_ready) resp_log.push_back(resp_id);
            end else begin
                check("resp_valid_low", 64'(resp_valid), 64'(0));
            end

            case (m_phase)
                M_IDLE: if (exp_grant != 2'b00) begin
                    g_id = exp_grant[1];
                    m_op = g_id ? req1_op : req0_op;
                    m_a  = g_id ? req1_a  : req0_a;
                    m_b  = g_id ? req1_b  : req0_b;
                    sb.push_back({g_id, alu_fn(m_op, m_a, m_b, ctrl_ref(m_op))});
                    m_ptr   = ~g_id;
                    m_phase = M_EXEC;
                end
                M_EXEC: m_phase = M_RESP;
                M_RESP: if (resp_ready) begin
                    if (sb.size() != 0) void'(sb.pop_front());
                    m_phase = M_IDLE;
                end
                default: m_phase = M_IDLE;
            endcase
        end
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_phase = M_IDLE;
        m_ptr = 1'b0;
        force_flags = 1'b0;
        rst = 1'b1;
        req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
        resp_ready = 1'b1;
        dec_ops[0] = 4'b1001; dec_exp[0] = 3'b011;
        dec_ops[1] = 4'b1010; dec_exp[1] = 3'b011;
        dec_ops[2] = 4'b1101; dec_exp[2] = 3'b010;
        dec_ops[3] = 4'b0000; dec_exp[3] = 3'b000;
        step(3);

        // Single request: SUB 5,3 -> ~5 + 3 + 1 = 0xFFFE.
        rst = 1'b0;
        req0_valid = 1'b1; req0_op = 4'b0001; req0_a = 16'd5; req0_b = 16'd3;
        #1 check("t1_ready", 64'({req1_ready, req0_ready}), 64'(2'b01));
        step(1);
        req0_valid = 1'b0;
        check("t1_ctrl", 64'({alu_inva, alu_invb, alu_cin}), 64'(3'b101));
        step(1);
        check("t1_resp", 64'({resp_valid, resp_id, resp_data}), 64'({1'b1, 1'b0, 16'hFFFE}));
        step(2);

        // Contention straight after reset: grants alternate 0,1,0,1.
        rst = 1'b1;
        step(1);
        grant_log.delete();
        resp_log.delete();
        rst = 1'b0;
        req0_valid = 1'b1; req0_op = 4'b0000; req0_a = 16'h1111; req0_b = 16'h2222;
        req1_valid = 1'b1; req1_op = 4'b1001; req1_a = 16'h0100; req1_b = 16'h0040;
        step(12);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("rr_grants", 64'(grant_log.size()), 64'(4));
        check("rr_resps",  64'(resp_log.size()),  64'(4));
        for (int i = 0; i < 4; i++) begin
            if (i < grant_log.size()) check("rr_grant_order", 64'(grant_log[i]), 64'(i % 2));
            if (i < resp_log.size())  check("rr_resp_order",  64'(resp_log[i]),  64'(i % 2));
        end
        step(2);

        // Backpressure: four RESP cycles with resp_ready low, req0 waiting.
        resp_ready = 1'b0;
        req1_valid = 1'b1; req1_op = 4'b1101; req1_a = 16'hF0F0; req1_b = 16'h0FF0;
        step(1);
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_op = 4'b0000; req0_a = 16'h7FFF; req0_b = 16'h0001;
        step(4);
        check("bp_held", 64'({resp_valid, resp_id, resp_data}), 64'({1'b1, 1'b1, 16'hF000}));
        resp_ready = 1'b1;
        step(1);
        check("bp_release", 64'({resp_valid, req0_ready}), 64'(2'b01));
        step(1);
        req0_valid = 1'b0;
        step(1);
        check("bp_ofl", 64'({resp_data, resp_zero, resp_ofl}), 64'({16'h8000, 1'b0, 1'b1}));
        step(1);

        // Control decode in EXEC.
        for (int i = 0; i < 4; i++) begin
            req0_valid = 1'b1; req0_op = dec_ops[i]; req0_a = 16'h1234; req0_b = 16'h00FF;
            step(1);
            req0_valid = 1'b0;
            check("ctrl_decode", 64'({alu_inva, alu_invb, alu_cin}), 64'(dec_exp[i]));
            step(2);
        end

        // Reset mid-EXEC, with req0 asking throughout the reset.
        req1_valid = 1'b1; req1_op = 4'b0001; req1_a = 16'h0003; req1_b = 16'h0009;
        step(1);
        req1_valid = 1'b0;
        req0_valid = 1'b1;
        #2 rst = 1'b1;
        #1 check("rst_async", 64'({req1_ready, req0_ready, resp_valid, resp_id, resp_data,
                                   resp_zero, resp_ofl, alu_op, alu_a, alu_b,
                                   alu_inva, alu_invb, alu_cin}), 64'(0));
        step(2);
        req0_valid = 1'b0;
        rst = 1'b0;
        step(3);
        check("rst_no_resp", 64'(resp_valid), 64'(0));
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1 check("rst_ptr", 64'({req1_ready, req0_ready}), 64'(2'b01));
        step(4);
        req0_valid = 1'b0; req1_valid = 1'b0;
        step(3);

        // Flag pass-through from a forced ALU result.
        force_flags = 1'b1;
        req0_valid = 1'b1; req0_op = 4'b0000; req0_a = 16'h0001; req0_b = 16'h0002;
        step(1);
        req0_valid = 1'b0;
        step(1);
        check("flags", 64'({resp_valid, resp_data, resp_zero, resp_ofl}),
              64'({1'b1, 16'h0000, 1'b1, 1'b1}));
        step(1);
        force_flags = 1'b0;
        step(3);

        check("sb_drained", 64'(sb.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
